// File: rtl/hdmi_audio_mixer.sv
// Divides clk_pixel_w to the HDMI audio sample clock and mixes the Apple speaker with Mockingboard audio.
// Optional feature: define HDMI_AUDIO_LPF_EN to add a shift-only one-pole low-pass filter per channel.
module hdmi_audio_mixer #(
  parameter int unsigned PIXEL_CLOCK_HZ = 27_000_000,
  parameter int unsigned AUDIO_RATE     = 44100,
  parameter int unsigned SPEAKER_HOLD   = 255,
  parameter logic [15:0] SPEAKER_LEVEL  = 16'h2000
) (
  input  logic        clk_pixel_w,
  input  logic        system_reset_n_w,
  input  logic        speaker_toggle_i,
  input  logic        speaker_en_i,
  input  logic [9:0]  mb_audio_l_i,
  input  logic [9:0]  mb_audio_r_i,
  output logic        clk_audio_o,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        sample_tick_o
);

  localparam int unsigned     DIV       = PIXEL_CLOCK_HZ / AUDIO_RATE;
  localparam int unsigned     CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [7:0]      HOLD_INIT = 8'(SPEAKER_HOLD);
  localparam logic [16:0]     SAT_MAX   = 17'h07FFF;

  // ---------------------------------------------------------------------------
  // Sample-rate divider
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_next;
  logic             tick;

  always_comb begin
    tick         = (div_cnt == CNT_LAST);
    div_cnt_next = tick ? '0 : div_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
    if (!system_reset_n_w) begin
      div_cnt     <= '0;
      clk_audio_o <= 1'b0;
    end else begin
      div_cnt     <= div_cnt_next;
      clk_audio_o <= (div_cnt_next < CNT_HALF);
    end
  end

  // ---------------------------------------------------------------------------
  // Speaker toggle: synchronise, detect either edge, stretch into a held level
  // ---------------------------------------------------------------------------
  logic       spk_sync1, spk_sync2, spk_sync3;
  logic       spk_edge;
  logic       edge_pending;
  logic [7:0] hold_cnt;
  logic [7:0] hold_next;
  logic       spk_active;

  // NOTE: outputs get a default before any branch so no path leaves them unassigned (no latch).
  always_comb begin
    spk_edge  = spk_sync2 ^ spk_sync3;
    hold_next = hold_cnt;
    if (edge_pending | spk_edge) begin
      hold_next = HOLD_INIT;
    end else if (hold_cnt != 8'd0) begin
      hold_next = hold_cnt - 1'b1;
    end
    spk_active = spk_sync3 & (hold_next != 8'd0) & speaker_en_i;
  end

  always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
    if (!system_reset_n_w) begin
      spk_sync1    <= 1'b0;
      spk_sync2    <= 1'b0;
      spk_sync3    <= 1'b0;
      edge_pending <= 1'b0;
      hold_cnt     <= 8'd0;
    end else begin
      spk_sync1 <= speaker_toggle_i;
      spk_sync2 <= spk_sync1;
      spk_sync3 <= spk_sync2;
      // An edge coinciding with the tick is consumed by that tick's reload.
      if (tick) begin
        edge_pending <= 1'b0;
        hold_cnt     <= hold_next;
      end else if (spk_edge) begin
        edge_pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mockingboard CDC: accept a word only once two consecutive captures agree
  // ---------------------------------------------------------------------------
  logic [1:0][9:0] mb_in;
  logic [1:0][9:0] mb_s1, mb_s2, mb_stable;

  assign mb_in = {mb_audio_r_i, mb_audio_l_i};

  always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
    if (!system_reset_n_w) begin
      mb_s1     <= '0;
      mb_s2     <= '0;
      mb_stable <= '0;
    end else begin
      mb_s1 <= mb_in;
      mb_s2 <= mb_s1;
      for (int ch = 0; ch < 2; ch++) begin
        if (mb_s1[ch] == mb_s2[ch]) mb_stable[ch] <= mb_s2[ch];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mix and saturate; index 0 is left, 1 is right
  // ---------------------------------------------------------------------------
  logic [1:0][16:0] mix_wide;
  logic [1:0][15:0] mix;
  logic [1:0][15:0] sample_next;
  logic [1:0][15:0] audio_q;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      mix_wide[ch] = {3'b000, mb_stable[ch], 4'b0000}
                   + (spk_active ? {1'b0, SPEAKER_LEVEL} : 17'd0);
      mix[ch]      = (mix_wide[ch] > SAT_MAX) ? 16'h7FFF : mix_wide[ch][15:0];
    end
  end

`ifdef HDMI_AUDIO_LPF_EN
  // acc settles at 8*mix, so acc[17:3] gives unity gain without a multiplier.
  logic [1:0][17:0] lpf_acc;
  logic [1:0][17:0] lpf_acc_next;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      lpf_acc_next[ch] = lpf_acc[ch] - (lpf_acc[ch] >> 3) + {2'b00, mix[ch]};
      sample_next[ch]  = {1'b0, lpf_acc_next[ch][17:3]};
    end
  end

  always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
    if (!system_reset_n_w) begin
      lpf_acc <= '0;
    end else if (tick) begin
      lpf_acc <= lpf_acc_next;
    end
  end
`else
  always_comb begin
    sample_next = mix;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output register: updates on the edge where clk_audio_o rises
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
    if (!system_reset_n_w) begin
      audio_q       <= '0;
      sample_tick_o <= 1'b0;
    end else begin
      sample_tick_o <= tick;
      if (tick) audio_q <= sample_next;
    end
  end

  assign audio_l_o = audio_q[0];
  assign audio_r_o = audio_q[1];

endmodule

// File: tb/tb_hdmi_audio_mixer.sv
// Self-checking bench for hdmi_audio_mixer: directed steps plus random stimulus against an input-history model.
module tb_hdmi_audio_mixer;

  localparam int          RATE  = 44100;
  localparam int          DIV   = 32;
  localparam int          PCLK  = DIV * RATE;
  localparam int          HOLD  = 255;
  localparam logic [15:0] LEVEL = 16'h2000;
  localparam int          MAXC  = 65536;

  logic        clk_pixel_w = 1'b0;
  logic        system_reset_n_w;
  logic        speaker_toggle_i;
  logic        speaker_en_i;
  logic [9:0]  mb_audio_l_i;
  logic [9:0]  mb_audio_r_i;
  logic        clk_audio_o;
  logic [15:0] audio_l_o;
  logic [15:0] audio_r_o;
  logic        sample_tick_o;

  hdmi_audio_mixer #(
    .PIXEL_CLOCK_HZ(PCLK),
    .AUDIO_RATE    (RATE),
    .SPEAKER_HOLD  (HOLD),
    .SPEAKER_LEVEL (LEVEL)
  ) dut (
    .clk_pixel_w     (clk_pixel_w),
    .system_reset_n_w(system_reset_n_w),
    .speaker_toggle_i(speaker_toggle_i),
    .speaker_en_i    (speaker_en_i),
    .mb_audio_l_i    (mb_audio_l_i),
    .mb_audio_r_i    (mb_audio_r_i),
    .clk_audio_o     (clk_audio_o),
    .audio_l_o       (audio_l_o),
    .audio_r_o       (audio_r_o),
    .sample_tick_o   (sample_tick_o)
  );

  always #5 clk_pixel_w = ~clk_pixel_w;

  int n_assert = 0;
  int n_fail   = 0;

  // Input history indexed by rising-edge number since reset release (edge 1 = first edge).
  int          edge_n;
  logic        spk_h [MAXC];
  logic        en_h  [MAXC];
  logic [9:0]  mbl_h [MAXC];
  logic [9:0]  mbr_h [MAXC];
  int          since;
  int          acc_l, acc_r;
  logic [15:0] exp_l, exp_r;

  int          cnt;
  int          diff;
  logic [15:0] prev;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, expv, edge_n);
    end
  endtask

  function automatic logic spk_at(input int k);
    return (k < 1) ? 1'b0 : spk_h[k];
  endfunction

  // The CDC output is the latest input word seen on two consecutive edges, at least one edge old.
  function automatic logic [9:0] mb_stable_at(input bit right, input int n);
    for (int i = n - 2; i >= 1; i--) begin
      if (right) begin
        if (mbr_h[i] == mbr_h[i + 1]) return mbr_h[i];
      end else begin
        if (mbl_h[i] == mbl_h[i + 1]) return mbl_h[i];
      end
    end
    return 10'd0;
  endfunction

  task automatic model_reset();
    edge_n = 0;
    since  = HOLD;
    acc_l  = 0;
    acc_r  = 0;
    exp_l  = 16'h0000;
    exp_r  = 16'h0000;
  endtask

  // Expected sample for the tick cycle that precedes edge edge_n.
  task automatic model_tick();
    int n;
    bit reload;
    bit active;
    int mix_l, mix_r;
    n      = edge_n - 1;
    reload = 1'b0;
    for (int i = n - DIV - 1; i <= n - 2; i++) begin
      if (spk_at(i) != spk_at(i + 1)) reload = 1'b1;
    end
    if (reload) since = 0;
    else if (since < HOLD) since++;
    active = spk_at(n - 2) && en_h[edge_n] && (since < HOLD);
    mix_l = int'(mb_stable_at(1'b0, n)) * 16 + (active ? int'(LEVEL) : 0);
    mix_r = int'(mb_stable_at(1'b1, n)) * 16 + (active ? int'(LEVEL) : 0);
    if (mix_l > 32767) mix_l = 32767;
    if (mix_r > 32767) mix_r = 32767;
`ifdef HDMI_AUDIO_LPF_EN
    acc_l = acc_l - (acc_l >>> 3) + mix_l;
    acc_r = acc_r - (acc_r >>> 3) + mix_r;
    exp_l = 16'(acc_l >>> 3);
    exp_r = 16'(acc_r >>> 3);
`else
    exp_l = 16'(mix_l);
    exp_r = 16'(mix_r);
`endif
  endtask

  // One clock: record inputs at the rising edge, compare all outputs on the falling edge.
  task automatic cycle();
    bit tick_exp;
    @(posedge clk_pixel_w);
    edge_n++;
    if (edge_n >= MAXC) begin
      $display("FAIL history_overflow: edge %0d exceeds %0d", edge_n, MAXC);
      $fatal(1, "history overflow");
    end
    spk_h[edge_n] = speaker_toggle_i;
    en_h[edge_n]  = speaker_en_i;
    mbl_h[edge_n] = mb_audio_l_i;
    mbr_h[edge_n] = mb_audio_r_i;
    @(negedge clk_pixel_w);
    tick_exp = ((edge_n % DIV) == 0);
    if (tick_exp) model_tick();
    check("sample_tick", 16'(sample_tick_o), 16'(tick_exp));
    check("clk_audio", 16'(clk_audio_o), 16'((edge_n % DIV) < (DIV / 2)));
    check("audio_l", audio_l_o, exp_l);
    check("audio_r", audio_r_o, exp_r);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic to_tick();
    do cycle(); while ((edge_n % DIV) != 0);
  endtask

  initial begin
    system_reset_n_w = 1'b0;
    speaker_toggle_i = 1'b0;
    speaker_en_i     = 1'b1;
    mb_audio_l_i     = 10'd0;
    mb_audio_r_i     = 10'd0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk_pixel_w);
    check("rst_clk_audio", 16'(clk_audio_o), 16'd0);
    check("rst_tick", 16'(sample_tick_o), 16'd0);
    check("rst_audio_l", audio_l_o, 16'h0000);
    check("rst_audio_r", audio_r_o, 16'h0000);
    system_reset_n_w = 1'b1;

    // Idle: divider period and duty are checked every cycle
    repeat (2) to_tick();

    // Mockingboard step
    mb_audio_l_i = 10'h3FF;
    mb_audio_r_i = 10'h100;
    to_tick();
`ifdef HDMI_AUDIO_LPF_EN
    check("lpf_first_l", audio_l_o, 16'h07FE);
    check("lpf_first_r", audio_r_o, 16'h0200);
    for (int k = 0; k < 80; k++) begin
      prev = audio_l_o;
      to_tick();
      check("lpf_monotonic", 16'(audio_l_o >= prev), 16'd1);
    end
    diff = int'(audio_l_o) - 16'h3FF0;
    if (diff < 0) diff = -diff;
    check("lpf_converge", 16'(diff <= 8), 16'd1);
`else
    check("mb_step_l", audio_l_o, 16'h3FF0);
    check("mb_step_r", audio_r_o, 16'h1000);
`endif

    // Single toggle 0->1 away from the tick: 255 active samples
    mb_audio_l_i = 10'd0;
    mb_audio_r_i = 10'd0;
    to_tick();
    run(3);
    speaker_toggle_i = 1'b1;
    cnt = 0;
    for (int k = 0; k < 260; k++) begin
      to_tick();
      if (audio_l_o === LEVEL) cnt++;
    end
`ifndef HDMI_AUDIO_LPF_EN
    check("spk_pulse_len", 16'(cnt), 16'd255);
`endif

    // Two toggles in one period with the speaker disabled, then enabled mid-hold
    speaker_en_i = 1'b0;
    run(5);
    speaker_toggle_i = 1'b0;
    run(10);
    speaker_toggle_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      to_tick();
`ifndef HDMI_AUDIO_LPF_EN
      check("spk_disabled", audio_l_o, 16'h0000);
`endif
    end
    speaker_en_i = 1'b1;
    cnt = 0;
    for (int k = 5; k < 260; k++) begin
      to_tick();
      if (audio_l_o === LEVEL) cnt++;
    end
`ifndef HDMI_AUDIO_LPF_EN
    check("spk_even_reload", 16'(cnt), 16'd250);
`endif

    // Toggle whose synchronised edge lands on the tick cycle
    run(3);
    speaker_toggle_i = 1'b0;
    repeat (3) to_tick();
    run(DIV - 3);
    speaker_toggle_i = 1'b1;
    cnt = 0;
    for (int k = 0; k < 260; k++) begin
      to_tick();
`ifndef HDMI_AUDIO_LPF_EN
      if (k == 0) check("spk_tick_edge_level", audio_l_o, 16'h0000);
`endif
      if (audio_l_o === LEVEL) cnt++;
    end
`ifndef HDMI_AUDIO_LPF_EN
    check("spk_tick_edge_len", 16'(cnt), 16'd254);
`endif

    // Mockingboard inputs changing every cycle, then held
    for (int k = 0; k < 20; k++) begin
      mb_audio_l_i = 10'($urandom_range(0, 1023));
      mb_audio_r_i = 10'($urandom_range(0, 1023));
      cycle();
    end
    mb_audio_l_i = 10'h155;
    mb_audio_r_i = 10'h155;
    repeat (2) to_tick();
`ifndef HDMI_AUDIO_LPF_EN
    check("mb_settle_l", audio_l_o, 16'h1550);
    check("mb_settle_r", audio_r_o, 16'h1550);
`endif

    // Randomised mix of all inputs
    for (int k = 0; k < 30 * DIV; k++) begin
      if ($urandom_range(0, 39) == 0) speaker_toggle_i = ~speaker_toggle_i;
      if ($urandom_range(0, 199) == 0) speaker_en_i = ~speaker_en_i;
      if ($urandom_range(0, 3) == 0) mb_audio_l_i = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) mb_audio_r_i = 10'($urandom_range(0, 1023));
      cycle();
    end
    speaker_en_i = 1'b1;

    // Asynchronous reset in the middle of a period
    mb_audio_l_i = 10'h155;
    mb_audio_r_i = 10'h155;
    repeat (2) to_tick();
    run(10);
    #2 system_reset_n_w = 1'b0;
    #1;
    check("midrst_clk_audio", 16'(clk_audio_o), 16'd0);
    check("midrst_tick", 16'(sample_tick_o), 16'd0);
    check("midrst_audio_l", audio_l_o, 16'h0000);
    check("midrst_audio_r", audio_r_o, 16'h0000);
    repeat (2) @(negedge clk_pixel_w);
    check("midrst_hold_clk_audio", 16'(clk_audio_o), 16'd0);
    check("midrst_hold_audio_l", audio_l_o, 16'h0000);
    model_reset();
    system_reset_n_w = 1'b1;
    repeat (3) to_tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
